// File: rtl/sico_trig_capture.sv
// Trigger-based stream capture: keeps a rolling pre-trigger history of handshaked beats,
// stores a bounded post-trigger window, then replays the window oldest-first on rec_o.
module sico_trig_capture #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  mon_valid_i,
  input  logic                  mon_ready_i,
  input  logic [WIDTH-1:0]      mon_data_i,
  input  logic                  arm_i,
  input  logic [AW-1:0]         cfg_pre_i,
  input  logic [AW:0]           cfg_post_i,
  input  logic                  trig_i,
  input  logic                  abort_i,
  output logic [WIDTH+AW+1:0]   rec_o,
  output logic [2:0]            state_o,
  output logic                  done_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARMED = 3'd1,
    S_POST  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  state_e           state_q, state_d;
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    fill_q, fill_d;
  logic [AW-1:0]    pre_q, pre_d;
  logic [AW:0]      post_q, post_d;
  logic [AW-1:0]    pre_used_q, pre_used_d;
  logic [AW:0]      post_cnt_q, post_cnt_d;
  logic [AW:0]      rd_cnt_q, rd_cnt_d;
  logic             vld_q, vld_d;
  logic             tmark_q, tmark_d;
  logic [AW-1:0]    seq_q, seq_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic             beat;
  logic             wr_en;
  logic [AW:0]      total;
  logic [AW:0]      room;
  logic [AW-1:0]    rd_idx;

  assign beat   = mon_valid_i & mon_ready_i;
  assign total  = {1'b0, pre_used_q} + post_cnt_q;
  assign room   = DEPTH_C - {1'b0, cfg_pre_i};
  // The window ends at wptr, so the oldest entry sits total slots behind it.
  assign rd_idx = wptr_q - total[AW-1:0] + rd_cnt_q[AW-1:0];

  // NOTE: every _d gets its hold value first so no path through the case leaves a latch.
  always_comb begin
    state_d    = state_q;
    wptr_d     = wptr_q;
    fill_d     = fill_q;
    pre_d      = pre_q;
    post_d     = post_q;
    pre_used_d = pre_used_q;
    post_cnt_d = post_cnt_q;
    rd_cnt_d   = rd_cnt_q;
    vld_d      = 1'b0;
    tmark_d    = 1'b0;
    seq_d      = seq_q;
    data_d     = data_q;
    wr_en      = 1'b0;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (arm_i) begin
          pre_d      = cfg_pre_i;
          post_d     = (cfg_post_i < room) ? cfg_post_i : room;
          wptr_d     = '0;
          fill_d     = '0;
          pre_used_d = '0;
          post_cnt_d = '0;
          rd_cnt_d   = '0;
          state_d    = S_ARMED;
        end
      end
      S_ARMED: begin
        if (trig_i) begin
          pre_used_d = fill_q;
          if (post_q == '0) begin
            state_d = S_DRAIN;
          end else begin
            // A beat on the trigger cycle is the first post-trigger beat.
            wr_en      = beat;
            wptr_d     = beat ? wptr_q + 1'b1 : wptr_q;
            post_cnt_d = beat ? (AW+1)'(1) : '0;
            state_d    = (beat && post_q == (AW+1)'(1)) ? S_DRAIN : S_POST;
          end
        end else if (beat) begin
          wr_en  = 1'b1;
          wptr_d = wptr_q + 1'b1;
          if (fill_q != pre_q) fill_d = fill_q + 1'b1;
        end
      end
      S_POST: begin
        if (beat) begin
          wr_en      = 1'b1;
          wptr_d     = wptr_q + 1'b1;
          post_cnt_d = post_cnt_q + 1'b1;
          if ((post_cnt_q + 1'b1) == post_q) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (total == '0) begin
          state_d = S_DONE;
        end else begin
          vld_d    = 1'b1;
          tmark_d  = (rd_cnt_q == {1'b0, pre_used_q});
          seq_d    = rd_cnt_q[AW-1:0];
          data_d   = mem_q[rd_idx];
          rd_cnt_d = rd_cnt_q + 1'b1;
          if (rd_cnt_q == total - 1'b1) state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (abort_i) begin
      state_d = S_IDLE;
      vld_d   = 1'b0;
      tmark_d = 1'b0;
      wr_en   = 1'b0;
    end
  end

  assign done_d = (state_d == S_DONE);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      wptr_q     <= '0;
      fill_q     <= '0;
      pre_q      <= '0;
      post_q     <= '0;
      pre_used_q <= '0;
      post_cnt_q <= '0;
      rd_cnt_q   <= '0;
      vld_q      <= 1'b0;
      tmark_q    <= 1'b0;
      seq_q      <= '0;
      data_q     <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wptr_q     <= wptr_d;
      fill_q     <= fill_d;
      pre_q      <= pre_d;
      post_q     <= post_d;
      pre_used_q <= pre_used_d;
      post_cnt_q <= post_cnt_d;
      rd_cnt_q   <= rd_cnt_d;
      vld_q      <= vld_d;
      tmark_q    <= tmark_d;
      seq_q      <= seq_d;
      data_q     <= data_d;
      done_q     <= done_d;
    end
  end

  // NOTE: the buffer is deliberately left unreset; only entries written in this capture are ever read.
  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wptr_q] <= mon_data_i;
  end

  assign rec_o   = {vld_q, tmark_q, seq_q, data_q};
  assign state_o = state_q;
  assign done_o  = done_q;

endmodule

// File: tb/tb_sico_trig_capture.sv
// Randomized bench for sico_trig_capture: a queue-based model of the capture window
// predicts every drained record, state sequence and reset/abort behaviour.
module tb_sico_trig_capture;

  localparam int W  = 8;
  localparam int D  = 16;
  localparam int AW = 4;
  localparam int RW = W + AW + 2;

  logic          clk = 1'b0;
  logic          rst, mv, mr, arm, trig, abort;
  logic [W-1:0]  md;
  logic [AW-1:0] cpre;
  logic [AW:0]   cpost;
  logic [RW-1:0] rec;
  logic [2:0]    st;
  logic          done;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sico_trig_capture #(.WIDTH(W), .DEPTH(D), .AW(AW)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .mon_valid_i(mv),
    .mon_ready_i(mr),
    .mon_data_i (md),
    .arm_i      (arm),
    .cfg_pre_i  (cpre),
    .cfg_post_i (cpost),
    .trig_i     (trig),
    .abort_i    (abort),
    .rec_o      (rec),
    .state_o    (st),
    .done_o     (done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    mv = 1'b0; mr = 1'b0; arm = 1'b0; trig = 1'b0; abort = 1'b0; rst = 1'b0;
  endtask

  // r=0: valid only, r=1: ready only, otherwise a real beat.
  task automatic rand_hs(output bit beat);
    int r;
    r  = $urandom_range(0, 3);
    mv = (r == 0 || r >= 2);
    mr = (r == 1 || r >= 2);
    beat = mv & mr;
  endtask

  task automatic capture(input int pre, input int post_req, input int n_pre, input bit trig_beat,
                         input bit rnd, input logic [7:0] base, input int kill_at, input bit kill_rst);
    logic [7:0] hist[$];
    logic [7:0] post_beats[$];
    logic [7:0] exp_q[$];
    logic [7:0] nxt;
    int         post_eff, pre_used, n;
    bit         b;

    nxt      = base;
    post_eff = (post_req < D - pre) ? post_req : D - pre;
    idle_inputs();
    cpre = 4'(pre); cpost = 5'(post_req); arm = 1'b1;
    tick();
    arm = 1'b0;
    check("arm_state", st, 1);

    // Rolling history: only the newest pre beats survive.
    n = 0;
    while (n < n_pre) begin
      rand_hs(b);
      md    = rnd ? 8'($urandom) : nxt;
      arm   = ($urandom_range(0, 7) == 0);
      cpre  = 4'($urandom);
      cpost = 5'($urandom);
      if (b) begin
        hist.push_back(md);
        if (hist.size() > pre) void'(hist.pop_front());
        n++;
        nxt++;
      end
      tick();
    end
    arm = 1'b0;
    check("armed_state", st, 1);

    mv = 1'b1; mr = trig_beat; trig = 1'b1;
    md = rnd ? 8'($urandom) : nxt;
    pre_used = hist.size();
    if (trig_beat) begin
      if (post_eff > 0) post_beats.push_back(md);
      nxt++;
    end
    tick();
    trig = 1'b0;
    check("trig_state", st, (post_beats.size() == post_eff) ? 3 : 2);

    while (post_beats.size() < post_eff) begin
      rand_hs(b);
      md   = rnd ? 8'($urandom) : nxt;
      trig = 1'($urandom_range(0, 1));
      if (b) begin
        post_beats.push_back(md);
        nxt++;
      end
      tick();
      check("post_state", st, (post_beats.size() == post_eff) ? 3 : 2);
    end
    mv = 1'b0; mr = 1'b0; trig = 1'b0;

    exp_q = {hist, post_beats};
    n = exp_q.size();
    if (n == 0) begin
      tick();
      check("drain_empty_vld", rec[RW-1:RW-2], 0);
      check("drain_empty_state", st, 4);
    end
    for (int k = 0; k < n; k++) begin
      mv = 1'($urandom); mr = 1'($urandom); trig = 1'($urandom); md = 8'($urandom);
      tick();
      check("drain_rec", rec, {1'b1, (k == pre_used), 4'(k), exp_q[k]});
      check("drain_state", st, (k == n - 1) ? 4 : 3);
      check("drain_done", done, (k == n - 1));
      if (k == kill_at) begin
        if (kill_rst) rst = 1'b1;
        else abort = 1'b1;
        arm = 1'b1; trig = 1'b1;
        tick();
        idle_inputs();
        check("kill_state", st, 0);
        check("kill_done", done, 0);
        if (kill_rst) check("kill_rec", rec, 0);
        else          check("kill_vld", rec[RW-1:RW-2], 0);
        return;
      end
    end

    mv = 1'b1; mr = 1'b1; trig = 1'b1;
    tick();
    idle_inputs();
    check("done_state", st, 4);
    check("done_flag", done, 1);
    if (n > 0) check("done_hold", rec, {2'b00, 4'(n - 1), exp_q[n-1]});
    else       check("done_novld", rec[RW-1:RW-2], 0);
  endtask

  initial begin
    idle_inputs();
    md = '0; cpre = '0; cpost = '0;
    rst = 1'b1; arm = 1'b1; trig = 1'b1; abort = 1'b1;
    tick();
    tick();
    idle_inputs();
    check("reset_state", st, 0);
    check("reset_rec", rec, 0);
    check("reset_done", done, 0);

    trig = 1'b1; mv = 1'b1; mr = 1'b1;
    tick();
    idle_inputs();
    check("idle_trig_ignored", st, 0);

    capture(4, 4, 10, 1'b1, 1'b0, 8'h10, -1, 1'b0);
    capture(4, 2, 2, 1'b0, 1'b0, 8'h01, -1, 1'b0);
    capture(3, 0, 5, 1'b1, 1'b0, 8'hA0, -1, 1'b0);
    capture(10, 10, 20, 1'b0, 1'b0, 8'h40, -1, 1'b0);
    capture(5, 6, 8, 1'b1, 1'b0, 8'h60, 3, 1'b1);
    capture(4, 4, 10, 1'b1, 1'b0, 8'h10, -1, 1'b0);
    capture(6, 5, 9, 1'b0, 1'b1, 8'h00, 2, 1'b0);

    cpre = 4'd2; cpost = 5'd2; arm = 1'b1;
    tick();
    arm = 1'b0;
    check("abort_pre_state", st, 1);
    abort = 1'b1; arm = 1'b1; trig = 1'b1;
    tick();
    idle_inputs();
    check("abort_priority", st, 0);

    capture(0, 0, 3, 1'b1, 1'b1, 8'h00, -1, 1'b0);

    for (int i = 0; i < 25; i++) begin
      capture(int'($urandom_range(0, 15)), int'($urandom_range(0, 31)), int'($urandom_range(0, 24)),
              1'($urandom_range(0, 1)), 1'b1, 8'h00, -1, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
